// File: rtl/sd_dac_bank_pkg.sv
// Shared types for the sigma-delta DAC bank: operating modes and small helpers.
package sd_dac_bank_pkg;

    typedef enum logic [1:0] {
        ModeExt  = 2'b00,
        ModeRamp = 2'b01,
        ModeTri  = 2'b10,
        ModeHold = 2'b11
    } mode_e;

    function automatic logic accepts_writes(input mode_e m);
        return (m == ModeExt) || (m == ModeHold);
    endfunction

    function automatic logic is_gen_mode(input mode_e m);
        return (m == ModeRamp) || (m == ModeTri);
    endfunction

endpackage

// File: rtl/sd_dac_chan.sv
// One first-order sigma-delta modulator: W+1 bit accumulator, carry bit is the output.
module sd_dac_chan #(
    parameter int unsigned W = 8
) (
    input  logic         CLK_i,
    input  logic         RSTn_i,
    input  logic [W-1:0] SAMPLE_i,
    output logic         DAC_o
);

    logic [W:0] acc_q;
    logic [W:0] acc_d;

    // The carry out of the previous sum is dropped before adding the next sample.
    always_comb begin
        acc_d = {1'b0, acc_q[W-1:0]} + {1'b0, SAMPLE_i};
    end

    always_ff @(posedge CLK_i or negedge RSTn_i) begin
        if (!RSTn_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign DAC_o = acc_q[W];

endmodule

// File: rtl/sd_dac_bank.sv
// N-channel sigma-delta DAC bank with double-buffered samples and a ramp/triangle generator.
module sd_dac_bank
    import sd_dac_bank_pkg::*;
#(
    parameter  int unsigned NCH        = 4,
    parameter  int unsigned W          = 8,
    parameter  int unsigned DIV_W      = 24,
    parameter  int unsigned PHASE_STEP = 64,
    localparam int unsigned CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             CLK_i,
    input  logic             RSTn_i,
    input  logic [1:0]       MODE_i,
    input  logic [DIV_W-1:0] DIV_i,
    input  logic             WR_VALID_i,
    output logic             WR_READY_o,
    input  logic [CH_W-1:0]  WR_CH_i,
    input  logic [W-1:0]     WR_DATA_i,
    input  logic             LOAD_i,
    output logic [NCH-1:0]   DAC_o,
    output logic             TICK_o,
    output logic             ERR_o,
    output logic [7:0]       LED_o
);

    mode_e            mode_in;
    mode_e            mode_q;
    logic             ready_q;
    logic             err_q, err_d;
    logic             tick_q, tick_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     gen_q, gen_d;
    logic             dir_q, dir_d;  // 0 = counting up
    logic [W-1:0]     shadow_q [NCH];
    logic [W-1:0]     active_q [NCH];

    logic             mode_chg;
    logic             gen_mode;
    logic             wr_fire;
    logic [31:0]      ch_idx;

    assign mode_in  = mode_e'(MODE_i);
    assign mode_chg = (mode_in != mode_q);
    assign gen_mode = is_gen_mode(mode_q);
    assign wr_fire  = WR_VALID_i && ready_q;
    assign ch_idx   = 32'(WR_CH_i);

    assign WR_READY_o = ready_q;
    assign TICK_o     = tick_q;
    assign ERR_o      = err_q;

    always_comb begin
        cnt_d  = cnt_q;
        gen_d  = gen_q;
        dir_d  = dir_q;
        tick_d = 1'b0;
        err_d  = wr_fire && (ch_idx >= NCH);
        if (mode_chg) begin
            cnt_d = '0;
            gen_d = '0;
            dir_d = 1'b0;
        end else if (gen_mode) begin
            if (cnt_q == DIV_i) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (mode_q == ModeRamp) begin
                    gen_d = gen_q + 1'b1;
                end else if (!dir_q) begin
                    // Turn around at the top without repeating the endpoint.
                    if (gen_q == {W{1'b1}}) begin
                        gen_d = gen_q - 1'b1;
                        dir_d = 1'b1;
                    end else begin
                        gen_d = gen_q + 1'b1;
                    end
                end else begin
                    if (gen_q == '0) begin
                        gen_d = gen_q + 1'b1;
                        dir_d = 1'b0;
                    end else begin
                        gen_d = gen_q - 1'b1;
                    end
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_i or negedge RSTn_i) begin
        if (!RSTn_i) begin
            mode_q  <= ModeExt;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            tick_q  <= 1'b0;
            cnt_q   <= '0;
            gen_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            mode_q  <= mode_in;
            ready_q <= accepts_writes(mode_in);
            err_q   <= err_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
            gen_q   <= gen_d;
            dir_q   <= dir_d;
        end
    end

    // A LOAD coinciding with a write copies the pre-write shadow value.
    always_ff @(posedge CLK_i or negedge RSTn_i) begin
        if (!RSTn_i) begin
            for (int k = 0; k < NCH; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (wr_fire && (ch_idx == 32'(k))) begin
                    shadow_q[k] <= WR_DATA_i;
                end
                if (gen_mode) begin
                    active_q[k] <= gen_q + W'(32'(k) * PHASE_STEP);
                end else if ((mode_q == ModeExt) && LOAD_i) begin
                    active_q[k] <= shadow_q[k];
                end
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        sd_dac_chan #(
            .W(W)
        ) u_chan (
            .CLK_i   (CLK_i),
            .RSTn_i  (RSTn_i),
            .SAMPLE_i(active_q[k]),
            .DAC_o   (DAC_o[k])
        );
    end

    if (W >= 8) begin : g_led_wide
        assign LED_o = active_q[0][W-1 -: 8];
    end else begin : g_led_narrow
        assign LED_o = {{(8 - W){1'b0}}, active_q[0]};
    end

endmodule

// File: tb/tb_sd_dac_bank.sv
// Directed bench for sd_dac_bank: reset, EXT load path, write errors, RAMP/TRI/HOLD modes.
module tb_sd_dac_bank;

    localparam int unsigned NCH   = 3;
    localparam int unsigned W     = 8;
    localparam int unsigned DIV_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic             wr_valid;
    logic             wr_ready;
    logic [1:0]       wr_ch;
    logic [W-1:0]     wr_data;
    logic             load;
    logic [NCH-1:0]   dac;
    logic             tick;
    logic             err;
    logic [7:0]       led;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sd_dac_bank #(
        .NCH       (NCH),
        .W         (W),
        .DIV_W     (DIV_W),
        .PHASE_STEP(64)
    ) dut (
        .CLK_i     (clk),
        .RSTn_i    (rst_n),
        .MODE_i    (mode),
        .DIV_i     (div),
        .WR_VALID_i(wr_valid),
        .WR_READY_o(wr_ready),
        .WR_CH_i   (wr_ch),
        .WR_DATA_i (wr_data),
        .LOAD_i    (load),
        .DAC_o     (dac),
        .TICK_o    (tick),
        .ERR_o     (err),
        .LED_o     (led)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int ones;
        int zeros0;
        int bad_gap;
        int first;
        int last;
        int ticks;

        rst_n    = 1'b0;
        mode     = 2'b00;
        div      = '0;
        wr_valid = 1'b0;
        wr_ch    = '0;
        wr_data  = '0;
        load     = 1'b0;
        step(2);
        rst_n = 1'b1;
        check("ready_low_after_release", 32'(wr_ready), 0);
        check("led_reset", 32'(led), 0);
        step(1);
        check("ready_ext", 32'(wr_ready), 1);

        // Get channel 0 toggling, then reset mid-cycle.
        wr_valid = 1'b1; wr_ch = 2'd0; wr_data = 8'h80;
        step(1);
        wr_valid = 1'b0; load = 1'b1;
        step(1);
        load = 1'b0;
        check("led_0x80", 32'(led), 32'h80);
        step(1);
        check("dac0_first_zero", 32'(dac[0]), 0);
        step(1);
        check("dac0_toggles_high", 32'(dac[0]), 1);
        #3 rst_n = 1'b0;
        #1;
        check("async_dac", 32'(dac), 0);
        check("async_led", 32'(led), 0);
        check("async_ready", 32'(wr_ready), 0);
        check("async_tick_err", {30'd0, tick, err}, 0);
        step(1);
        rst_n = 1'b1;
        check("ready_low_before_edge", 32'(wr_ready), 0);
        step(1);
        check("ready_after_edge", 32'(wr_ready), 1);

        // EXT: ch1 = 0x40 gives exactly one high every fourth clock.
        wr_valid = 1'b1; wr_ch = 2'd1; wr_data = 8'h40;
        step(1);
        wr_valid = 1'b0; load = 1'b1;
        step(1);
        load = 1'b0;
        check("active1_0x40", 32'(dut.active_q[1]), 32'h40);
        ones = 0; zeros0 = 0; bad_gap = 0; first = -1; last = -1;
        for (int i = 1; i <= 256; i++) begin
            step(1);
            if (dac[0] || dac[2]) zeros0++;
            if (dac[1]) begin
                ones++;
                if (first < 0) first = i;
                if (last >= 0 && (i - last) != 4) bad_gap++;
                last = i;
            end
        end
        check("dac1_ones_per_256", ones, 64);
        check("dac1_first_high_latency", first, 4);
        check("dac1_gap_errors", bad_gap, 0);
        check("dac0_dac2_stay_low", zeros0, 0);

        // Write and LOAD in the same cycle: active keeps the old value.
        wr_valid = 1'b1; wr_ch = 2'd2; wr_data = 8'hAA; load = 1'b1;
        step(1);
        wr_valid = 1'b0; load = 1'b0;
        check("active2_pre_write", 32'(dut.active_q[2]), 0);
        check("shadow2_written", 32'(dut.shadow_q[2]), 32'hAA);
        load = 1'b1;
        step(1);
        load = 1'b0;
        check("active2_second_load", 32'(dut.active_q[2]), 32'hAA);

        // Out-of-range channel: accepted, dropped, one ERR pulse.
        wr_valid = 1'b1; wr_ch = 2'd3; wr_data = 8'h55;
        step(1);
        wr_valid = 1'b0;
        check("err_pulse", 32'(err), 1);
        check("oor_shadow0", 32'(dut.shadow_q[0]), 0);
        check("oor_shadow1", 32'(dut.shadow_q[1]), 32'h40);
        check("oor_shadow2", 32'(dut.shadow_q[2]), 32'hAA);
        step(1);
        check("err_one_cycle", 32'(err), 0);

        // RAMP with DIV = 3.
        mode = 2'b01; div = 8'd3;
        step(1);
        check("ramp_ready_low", 32'(wr_ready), 0);
        step(1);
        check("ramp_active0_start", 32'(led), 0);
        check("ramp_active1_start", 32'(dut.active_q[1]), 64);
        step(3);
        check("ramp_first_tick", 32'(tick), 1);
        step(1);
        check("ramp_tick_one_cycle", 32'(tick), 0);
        check("ramp_active0_1", 32'(led), 1);
        ticks = 0;
        for (int i = 0; i < 1016; i++) begin
            step(1);
            if (tick) ticks++;
        end
        check("ramp_tick_count", ticks, 254);
        check("ramp_active0_255", 32'(led), 255);
        check("ramp_active1_wrap", 32'(dut.active_q[1]), 63);
        step(4);
        check("ramp_active0_wrap0", 32'(led), 0);
        check("ramp_active1_64", 32'(dut.active_q[1]), 64);

        // TRI with DIV = 0: turnarounds without repeated endpoints.
        mode = 2'b10; div = 8'd0;
        step(1);
        step(255);
        check("tri_254_up", 32'(led), 254);
        step(1);
        check("tri_255_top", 32'(led), 255);
        step(1);
        check("tri_254_down", 32'(led), 254);
        step(253);
        check("tri_1_down", 32'(led), 1);
        step(1);
        check("tri_0_bottom", 32'(led), 0);
        step(1);
        check("tri_1_up", 32'(led), 1);
        check("tri_tick_every_clock", 32'(tick), 1);

        // HOLD mid-sweep.
        mode = 2'b11;
        step(1);
        check("hold_ready", 32'(wr_ready), 1);
        check("hold_last_gen", 32'(led), 2);
        step(5);
        check("hold_frozen0", 32'(led), 2);
        check("hold_frozen1", 32'(dut.active_q[1]), 66);
        wr_valid = 1'b1; wr_ch = 2'd0; wr_data = 8'h11;
        step(1);
        wr_valid = 1'b0;
        check("hold_shadow_write", 32'(dut.shadow_q[0]), 32'h11);
        load = 1'b1;
        step(1);
        load = 1'b0;
        check("hold_load_ignored", 32'(led), 2);

        // RAMP -> EXT -> RAMP restarts the generator.
        mode = 2'b01; div = 8'd0;
        step(6);
        check("ramp2_active0_4", 32'(led), 4);
        load = 1'b1;
        step(1);
        load = 1'b0;
        check("ramp_load_ignored", 32'(led), 5);
        mode = 2'b00;
        step(2);
        check("ext_frozen_after_ramp", 32'(led), 6);
        mode = 2'b01;
        step(2);
        check("ramp_restart_0", 32'(led), 0);
        step(1);
        check("ramp_restart_1", 32'(led), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
